// File: rtl/serial_adder_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_if
// Request/result bundle for the bit-serial adder.
//   start       : request, sampled only while the adder is not busy
//   a, b, cin   : operands, captured on the accepting edge
//   busy        : addition in progress
//   done        : one-cycle completion pulse
//   sum, cout   : registered result, held until the next completion
//   ovf         : signed overflow (present only with SERIAL_ADD_OVF_EN)
// Modports: master drives requests, slave (the adder) drives results.
// Optional feature macro: SERIAL_ADD_OVF_EN
// -----------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial WIDTH-bit adder: captures operands on start, adds LSB-first one
// bit per clock through a 1-bit full-adder slice, then presents a registered
// {cout,sum} with a one-cycle done pulse. Back-to-back requests are accepted
// in the DONE cycle.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : serial_adder_ctrl_if.slave (start/a/b/cin in, busy/done/sum/cout out)
// Parameters:
//   WIDTH : operand/result width, 1..32
// Optional feature macro: SERIAL_ADD_OVF_EN (adds registered bus.ovf)
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_adder_ctrl_if.slave   bus
);
    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             fa_sum_c;
    logic             fa_cout_c;
    logic [WIDTH-1:0] sum_sr_nx_c;
    logic             accept_c;
    logic             last_c;

    // 1-bit full-adder slice fed from the operand LSBs and the running carry
    assign fa_sum_c  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign fa_cout_c = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB
    assign sum_sr_nx_c = (sum_sr_q >> 1) | (WIDTH'(fa_sum_c) << (WIDTH - 1));

    assign accept_c = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_c   = (state_q == S_RUN) && (bit_cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (last_c)    state_d = S_DONE;
            S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        sum_sr_d  = sum_sr_q;
        carry_d   = carry_q;
        bit_cnt_d = bit_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sum_d     = sum_q;
        cout_d    = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d     = ovf_q;
`endif
        if (accept_c) begin
            a_sr_d    = bus.a;
            b_sr_d    = bus.b;
            carry_d   = bus.cin;
            sum_sr_d  = '0;
            bit_cnt_d = '0;
            busy_d    = 1'b1;
        end else if (state_q == S_RUN) begin
            a_sr_d    = a_sr_q >> 1;
            b_sr_d    = b_sr_q >> 1;
            carry_d   = fa_cout_c;
            sum_sr_d  = sum_sr_nx_c;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (last_c) begin
                sum_d  = sum_sr_nx_c;
                cout_d = fa_cout_c;
`ifdef SERIAL_ADD_OVF_EN
                // carry_q is the carry into the MSB on this final step
                ovf_d  = carry_q ^ fa_cout_c;
`endif
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            sum_sr_q  <= '0;
            carry_q   <= 1'b0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            sum_sr_q  <= sum_sr_d;
            carry_q   <= carry_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Directed bench for serial_adder_ctrl: a WIDTH=8 instance and a WIDTH=1
// instance share clock and reset. Expected values are hand-computed.
// Optional feature macro: SERIAL_ADD_OVF_EN (also checks ovf)
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    serial_adder_ctrl_if #(.WIDTH(8)) i8 ();
    serial_adder_ctrl_if #(.WIDTH(1)) i1 ();

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(i8));
    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(i1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the 8-bit result outputs in a done cycle
    task automatic chk_result8(input string tag, input logic [7:0] s, input logic c, input logic o);
        chk({tag, "_done"}, 32'(i8.done), 32'd1);
        chk({tag, "_busy"}, 32'(i8.busy), 32'd0);
        chk({tag, "_sum"},  32'(i8.sum),  32'(s));
        chk({tag, "_cout"}, 32'(i8.cout), 32'(c));
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, "_ovf"},  32'(i8.ovf),  32'(o));
`else
        if (o === 1'bx) $display("unused");
`endif
    endtask

    // Checks the 8 busy cycles following an accepting edge; sum must hold
    task automatic chk_busy8(input string tag, input logic [7:0] held);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_busy"}, 32'(i8.busy), 32'd1);
            chk({tag, "_nodone"}, 32'(i8.done), 32'd0);
            chk({tag, "_hold"}, 32'(i8.sum), 32'(held));
            tick();
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
        i8.start = 1'b1;
        i8.a     = a;
        i8.b     = b;
        i8.cin   = c;
        tick();
        i8.start = 1'b0;
        i8.a     = 8'h00;
        i8.b     = 8'h00;
        i8.cin   = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        i8.start = 1'b0; i8.a = '0; i8.b = '0; i8.cin = 1'b0;
        i1.start = 1'b0; i1.a = '0; i1.b = '0; i1.cin = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", 32'(i8.busy), 32'd0);
        chk("rst_done", 32'(i8.done), 32'd0);
        chk("rst_sum",  32'(i8.sum),  32'd0);
        chk("rst_cout", 32'(i8.cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf",  32'(i8.ovf),  32'd0);
`endif

        // 0x5A + 0x33 -> 0x8D, signed overflow
        op8(8'h5A, 8'h33, 1'b0);
        chk_busy8("t1", 8'h00);
        chk_result8("t1", 8'h8D, 1'b0, 1'b1);
        tick();
        chk("t1_pulse", 32'(i8.done), 32'd0);
        chk("t1_held",  32'(i8.sum),  32'h8D);

        // 0xFF + 0x01 -> 0x00 carry out
        op8(8'hFF, 8'h01, 1'b0);
        chk_busy8("t2", 8'h8D);
        chk_result8("t2", 8'h00, 1'b1, 1'b0);
        tick();

        // 0xFF + 0xFF + 1 -> 0x1FF
        op8(8'hFF, 8'hFF, 1'b1);
        chk_busy8("t3", 8'h00);
        chk_result8("t3", 8'hFF, 1'b1, 1'b0);
        tick();

        // start held high: mid-run operand changes ignored, next op taken in DONE
        i8.start = 1'b1; i8.a = 8'h10; i8.b = 8'h20; i8.cin = 1'b0;
        tick();
        i8.a = 8'h7F; i8.b = 8'h01;
        chk_busy8("t4a", 8'hFF);
        chk_result8("t4a", 8'h30, 1'b0, 1'b0);
        tick();
        i8.start = 1'b0; i8.a = 8'h00; i8.b = 8'h00;
        chk_busy8("t4b", 8'h30);
        chk_result8("t4b", 8'h80, 1'b0, 1'b1);
        tick();

        // reset mid-run aborts with no done pulse
        op8(8'hAA, 8'h55, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", 32'(i8.busy), 32'd0);
        chk("t5_done", 32'(i8.done), 32'd0);
        chk("t5_sum",  32'(i8.sum),  32'd0);
        chk("t5_cout", 32'(i8.cout), 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk("t5_nodone", 32'(i8.done), 32'd0);
            tick();
        end
        op8(8'h01, 8'h01, 1'b0);
        chk_busy8("t5", 8'h00);
        chk_result8("t5", 8'h02, 1'b0, 1'b0);
        tick();

        // WIDTH=1 instance: all operand combinations, done one edge after accept
        for (int k = 0; k < 8; k++) begin
            logic [1:0] exp2;
            exp2 = 2'(k & 1) + 2'((k >> 1) & 1) + 2'((k >> 2) & 1);
            i1.start = 1'b1;
            i1.a     = 1'(k);
            i1.b     = 1'(k >> 1);
            i1.cin   = 1'(k >> 2);
            tick();
            i1.start = 1'b0;
            chk("w1_busy",   32'(i1.busy), 32'd1);
            chk("w1_nodone", 32'(i1.done), 32'd0);
            tick();
            chk("w1_done", 32'(i1.done), 32'd1);
            chk("w1_busy0", 32'(i1.busy), 32'd0);
            chk("w1_res",  32'({i1.cout, i1.sum}), 32'(exp2));
`ifdef SERIAL_ADD_OVF_EN
            chk("w1_ovf",  32'(i1.ovf), 32'(exp2[1] ^ 1'(k >> 2)));
`endif
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
